// File: rtl/update_knn8_mul_arb_pkg.sv
// Shared constants, tag type and counter helper for the kNN update multiplier arbiter.
package update_knn8_mul_arb_pkg;

  localparam int MUL_LAT    = 2;
  localparam int PERF_CNT_W = 16;
  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W   = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] cnt);
    return (cnt == {PERF_CNT_W{1'b1}}) ? cnt : cnt + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/update_knn8_mul_arb_if.sv
// Request/response bundle between the distance-update lanes and the shared multiplier arbiter.
interface update_knn8_mul_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 17,
  parameter int B_WIDTH = 15,
  parameter int P_WIDTH = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_stall;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [P_WIDTH-1:0]         rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_stall,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_stall,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/update_knn8_mul2.sv
// Two-stage unsigned multiplier: registered operands, registered product, shared clock enable.
module update_knn8_mul2 #(
  parameter int A_WIDTH = 17,
  parameter int B_WIDTH = 15,
  parameter int P_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  logic [P_WIDTH-1:0] p_q;

  // Operand and product registers advance together only when ce is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else if (ce) begin
      a_q <= a;
      b_q <= b;
      p_q <= P_WIDTH'(a_q) * P_WIDTH'(b_q);
    end else begin
      a_q <= a_q;
      b_q <= b_q;
      p_q <= p_q;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/update_knn8_rr_arb.sv
// Round-robin picker: one-hot grant starting the search at rr_ptr, pointer advances past each winner.
module update_knn8_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic            any_s;
  logic            found_s;
  logic            hit_s;
  logic [ID_W-1:0] idx_s;
  int              sum_s;

  // First requester at or after ptr_q (modulo NUM_REQ) wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = '0;
    sum_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s        = int'(ptr_q) + k;
      idx_s        = (sum_s >= NUM_REQ) ? ID_W'(sum_s - NUM_REQ) : ID_W'(sum_s);
      hit_s        = en & ~found_s & req[idx_s];
      gnt[idx_s]   = gnt[idx_s] | hit_s;
      gnt_id       = hit_s ? idx_s : gnt_id;
      found_s      = found_s | hit_s;
    end
  end

  // Next pointer: one past the winner, wrapping at NUM_REQ-1.
  always_comb begin
    any_s = |gnt;
    ptr_d = any_s ? ((gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1)) : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/update_knn8_mul_arb.sv
// Shares one 2-cycle multiplier between NUM_REQ requesters with tagged responses.
// Optional counters enabled by defining UPDATE_KNN8_MUL_ARB_PERF_EN.
module update_knn8_mul_arb
  import update_knn8_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 17,
  parameter int B_WIDTH = 15,
  parameter int P_WIDTH = 32,
  parameter int ID_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  update_knn8_mul_arb_if.slave         bus
`ifdef UPDATE_KNN8_MUL_ARB_PERF_EN
  ,
  input  logic                         perf_clr,
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grants,
  output logic [PERF_CNT_W-1:0]        perf_stall
`endif
);

  logic               ce_s;
  logic               en_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic [A_WIDTH-1:0] a_mux_s;
  logic [B_WIDTH-1:0] b_mux_s;
  logic [P_WIDTH-1:0] p_s;
  tag_t               tag_d;
  tag_t               tag_q [MUL_LAT];
  logic [NUM_REQ-1:0] rsp_valid_s;

  assign ce_s = ~bus.rsp_stall;
  // Gating with reset keeps req_ready low for the whole reset assertion.
  assign en_s = ce_s & reset;

  update_knn8_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req_valid),
    .en     (en_s),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign bus.req_ready = gnt_s;

  // One-hot operand mux; OR of masked slices gives zeros when nothing is granted.
  always_comb begin
    a_mux_s = '0;
    b_mux_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_mux_s = a_mux_s | (gnt_s[i] ? bus.req_a[i*A_WIDTH +: A_WIDTH] : {A_WIDTH{1'b0}});
      b_mux_s = b_mux_s | (gnt_s[i] ? bus.req_b[i*B_WIDTH +: B_WIDTH] : {B_WIDTH{1'b0}});
    end
  end

  update_knn8_mul2 #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_s),
    .a     (a_mux_s),
    .b     (b_mux_s),
    .p     (p_s)
  );

  // Tag entering the pipe alongside the operands.
  always_comb begin
    tag_d       = '0;
    tag_d.valid = |gnt_s;
    tag_d.id    = TAG_ID_W'(gnt_id_s);
  end

  // Tag pipe mirrors the multiplier stages so each product leaves with its owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else if (ce_s) begin
      tag_q[0] <= tag_d;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end else begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_q[s] <= tag_q[s];
      end
    end
  end

  // Decode the last tag stage into the one-hot response strobe.
  always_comb begin
    rsp_valid_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_s[i] = tag_q[MUL_LAT-1].valid & (tag_q[MUL_LAT-1].id == TAG_ID_W'(i));
    end
  end

  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
  assign bus.rsp_p     = p_s;

`ifdef UPDATE_KNN8_MUL_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] gnt_cnt_q   [NUM_REQ];
  logic [PERF_CNT_W-1:0] gnt_cnt_d   [NUM_REQ];
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] stall_cnt_d;

  // Clear has priority over increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_cnt_d[i] = perf_clr ? '0 :
                     ((gnt_s[i] & bus.req_valid[i]) ? sat_inc(gnt_cnt_q[i]) : gnt_cnt_q[i]);
    end
    stall_cnt_d = perf_clr ? '0 :
                  ((bus.rsp_stall & tag_q[MUL_LAT-1].valid) ? sat_inc(stall_cnt_q) : stall_cnt_q);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_cnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_cnt_q[i] <= gnt_cnt_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flatten per-requester counters onto the output bus.
  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      perf_grants[i*PERF_CNT_W +: PERF_CNT_W] = gnt_cnt_q[i];
    end
  end

  assign perf_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_update_knn8_mul_arb.sv
// Randomised and directed checks of the shared multiplier arbiter against a behavioural model.
module tb_update_knn8_mul_arb;

  localparam int NR = 4;
  localparam int AW = 17;
  localparam int BW = 15;
  localparam int PW = 32;
  localparam int IW = 2;

  logic clk;
  logic reset;

  update_knn8_mul_arb_if #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_W(IW)) ifc ();

`ifdef UPDATE_KNN8_MUL_ARB_PERF_EN
  logic              perf_clr;
  logic [NR*16-1:0]  perf_grants;
  logic [15:0]       perf_stall;
`endif

  update_knn8_mul_arb #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifc)
`ifdef UPDATE_KNN8_MUL_ARB_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  // Model: round-robin pointer plus list of in-flight results, oldest at index 1.
  int          m_ptr;
  logic        m_v  [2];
  int          m_id [2];
  logic [31:0] m_p  [2];

  logic [NR-1:0] e_ready, o_ready, e_rv, o_rv;
  logic [IW-1:0] e_id, o_id;
  logic [31:0]   e_p, o_p;

  function automatic int mgrant(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic mreset();
    m_ptr = 0;
    for (int s = 0; s < 2; s++) begin
      m_v[s] = 1'b0; m_id[s] = 0; m_p[s] = 32'd0;
    end
  endtask

  // One clock cycle: called just after a rising edge with inputs already applied.
  task automatic tick();
    int g;
    logic st;
    logic [31:0] pn;
    #2;
    st = ifc.rsp_stall;
    g = st ? -1 : mgrant(ifc.req_valid);
    e_ready = (g >= 0) ? NR'(1 << g) : '0;
    o_ready = ifc.req_ready;
    pn = 32'd0;
    if (g >= 0) pn = 32'(ifc.req_a[g*AW +: AW]) * 32'(ifc.req_b[g*BW +: BW]);
    @(posedge clk);
    if (!st) begin
      m_v[1] = m_v[0]; m_id[1] = m_id[0]; m_p[1] = m_p[0];
      m_v[0] = (g >= 0); m_id[0] = (g >= 0) ? g : 0; m_p[0] = pn;
      if (g >= 0) m_ptr = (g + 1) % NR;
    end
    #1;
    e_rv = m_v[1] ? NR'(1 << m_id[1]) : '0;
    e_id = IW'(m_id[1]);
    e_p  = m_p[1];
    o_rv = ifc.rsp_valid;
    o_id = ifc.rsp_id;
    o_p  = ifc.rsp_p;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifc.req_valid = '1;
    ifc.req_a = '1;
    ifc.req_b = '1;
    ifc.rsp_stall = 1'b0;
`ifdef UPDATE_KNN8_MUL_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", ifc.req_ready); end
    n_chk++; if (ifc.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", ifc.rsp_valid); end
    n_chk++; if (ifc.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", ifc.rsp_id); end
    n_chk++; if (ifc.rsp_p !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_p: got %h expected 0", ifc.rsp_p); end
    ifc.req_valid = '0;
    reset = 1'b1;
    mreset();
  endtask

  task automatic test_rotate();
    for (int i = 0; i < NR; i++) begin
      ifc.req_a[i*AW +: AW] = AW'(i + 1);
      ifc.req_b[i*BW +: BW] = BW'(10);
    end
    ifc.req_valid = '1;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) ifc.req_valid = '0;
      tick();
      if (k < 8) begin
        n_chk++; if (o_ready !== NR'(1 << (k % NR))) begin n_fail++; $display("FAIL rotate_grant k=%0d: got %b expected %b", k, o_ready, NR'(1 << (k % NR))); end
      end
      if (k >= 1) begin
        n_chk++; if (o_rv !== NR'(1 << ((k - 1) % NR))) begin n_fail++; $display("FAIL rotate_rsp_valid k=%0d: got %b expected %b", k, o_rv, NR'(1 << ((k - 1) % NR))); end
        n_chk++; if (o_p !== 32'(10 * ((k - 1) % NR + 1))) begin n_fail++; $display("FAIL rotate_rsp_p k=%0d: got %0d expected %0d", k, o_p, 10 * ((k - 1) % NR + 1)); end
      end
    end
    tick();
  endtask

  task automatic test_single();
    ifc.req_valid = 4'b0001;
    ifc.req_a[0 +: AW] = 17'h1FFFF;
    ifc.req_b[0 +: BW] = 15'h7FFF;
    tick();
    n_chk++; if (o_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", o_ready); end
    n_chk++; if (o_rv !== 4'b0000) begin n_fail++; $display("FAIL single_early: got %b expected 0000", o_rv); end
    ifc.req_valid = '0;
    tick();
    n_chk++; if (o_rv !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0001", o_rv); end
    n_chk++; if (o_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d expected 0", o_id); end
    n_chk++; if (o_p !== 32'hFFFD8001) begin n_fail++; $display("FAIL single_rsp_p: got %h expected fffd8001", o_p); end
    tick();
    n_chk++; if (o_rv !== 4'b0000) begin n_fail++; $display("FAIL single_once: got %b expected 0000", o_rv); end
  endtask

  task automatic test_wrap();
    ifc.req_valid = 4'b0100;
    tick();
    ifc.req_valid = 4'b1001;
    tick();
    n_chk++; if (o_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b expected 1000", o_ready); end
    tick();
    n_chk++; if (o_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_second: got %b expected 0001", o_ready); end
    ifc.req_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_stall();
    logic [NR-1:0] s_rv;
    logic [IW-1:0] s_id;
    logic [31:0]   s_p;
    int            seen;
    ifc.req_valid = 4'b0011;
    ifc.req_a[0 +: AW] = 17'd123; ifc.req_b[0 +: BW] = 15'd45;
    ifc.req_a[AW +: AW] = 17'd999; ifc.req_b[BW +: BW] = 15'd7;
    repeat (2) tick();
    s_rv = o_rv; s_id = o_id; s_p = o_p;
    seen = (o_rv != '0) ? 1 : 0;
    ifc.req_valid = 4'b1111;
    ifc.rsp_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (o_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready k=%0d: got %b expected 0000", k, o_ready); end
      n_chk++; if ({o_rv, o_id, o_p} !== {s_rv, s_id, s_p}) begin n_fail++; $display("FAIL stall_hold k=%0d: got %b/%0d/%h expected %b/%0d/%h", k, o_rv, o_id, o_p, s_rv, s_id, s_p); end
    end
    ifc.rsp_stall = 1'b0;
    ifc.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_rv != '0) seen++;
      n_chk++; if ({o_rv, o_p} !== {e_rv, e_p}) begin n_fail++; $display("FAIL stall_release k=%0d: got %b/%h expected %b/%h", k, o_rv, o_p, e_rv, e_p); end
    end
    n_chk++; if (seen !== 2) begin n_fail++; $display("FAIL stall_count: got %0d responses expected 2", seen); end
  endtask

  task automatic test_reset_mid();
    ifc.req_valid = 4'b1111;
    repeat (2) tick();
    reset = 1'b0;
    #2;
    n_chk++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 0000", ifc.req_ready); end
    n_chk++; if (ifc.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rsp_valid: got %b expected 0000", ifc.rsp_valid); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    mreset();
    ifc.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (o_rv !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flushed k=%0d: got %b expected 0000", k, o_rv); end
    end
    ifc.req_valid = 4'b1111;
    tick();
    n_chk++; if (o_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr: got %b expected 0001", o_ready); end
    ifc.req_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ifc.req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        ifc.req_a[i*AW +: AW] = AW'($urandom);
        ifc.req_b[i*BW +: BW] = BW'($urandom);
      end
      ifc.rsp_stall = ($urandom_range(0, 4) == 0);
      tick();
      n_chk++; if (o_ready !== e_ready) begin n_fail++; $display("FAIL rand_ready k=%0d: got %b expected %b", k, o_ready, e_ready); end
      n_chk++; if ({o_rv, o_p} !== {e_rv, e_p}) begin n_fail++; $display("FAIL rand_rsp k=%0d: got %b/%h expected %b/%h", k, o_rv, o_p, e_rv, e_p); end
      if (e_rv != '0) begin
        n_chk++; if (o_id !== e_id) begin n_fail++; $display("FAIL rand_id k=%0d: got %0d expected %0d", k, o_id, e_id); end
      end
    end
    ifc.rsp_stall = 1'b0;
    ifc.req_valid = '0;
    repeat (2) tick();
  endtask

`ifdef UPDATE_KNN8_MUL_ARB_PERF_EN
  task automatic test_perf();
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    ifc.req_valid = 4'b0100;
    repeat (70000) @(posedge clk);
    #1;
    ifc.req_valid = '0;
    n_chk++; if (perf_grants[2*16 +: 16] !== 16'hFFFF) begin n_fail++; $display("FAIL perf_sat: got %h expected ffff", perf_grants[2*16 +: 16]); end
    n_chk++; if (perf_grants[0 +: 16] !== 16'h0000) begin n_fail++; $display("FAIL perf_other: got %h expected 0000", perf_grants[0 +: 16]); end
    n_chk++; if (perf_stall !== 16'h0000) begin n_fail++; $display("FAIL perf_stall: got %h expected 0000", perf_stall); end
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    n_chk++; if (perf_grants[2*16 +: 16] !== 16'h0000) begin n_fail++; $display("FAIL perf_clr: got %h expected 0000", perf_grants[2*16 +: 16]); end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mreset();
    test_reset();
    test_rotate();
    test_single();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef UPDATE_KNN8_MUL_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
